// File: rtl/edid_pkg.sv
// Shared encodings for the EDID DDC reader: FSM states, bit-engine commands and quarter phases.
package edid_pkg;

  typedef enum logic [3:0] {
    StIdle, StStart, StWbyte, StWack, StRstart, StRbyte, StMack, StStop, StDone, StErr
  } state_e;

  typedef enum logic [1:0] {CmdStart, CmdStop, CmdWrite, CmdRead} cmd_e;

  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} phase_e;

  localparam logic [7:0] DDC_WORD_ADDR = 8'h00;

  function automatic logic [7:0] addr_byte(input logic [6:0] dev, input logic rd);
    return {dev, rd};
  endfunction

endpackage

// File: rtl/edid_i2c_bit.sv
// Quarter-bit tick divider plus 4-phase DDC bit engine (START, STOP, write bit, read bit).
module edid_i2c_bit
  import edid_pkg::*;
#(
  parameter int unsigned CLK_DIV = 62
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic       i_cmd_valid,
  input  logic [1:0] i_cmd,
  input  logic       i_bit,
  input  logic       i_sda,
  output logic       o_cmd_done,
  output logic       o_bit,
  output logic       o_scl_oe,
  output logic       o_sda_oe
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DivW-1:0] r_div;
  phase_e          r_phase;
  cmd_e            r_cmd;
  cmd_e            w_cmd;
  logic            w_tick;

  assign w_cmd      = cmd_e'(i_cmd);
  assign w_tick     = i_en && (r_div == DivW'(CLK_DIV - 1));
  // The q3 tick ends q2, so sda_i is still valid with SCL high at this point.
  assign o_cmd_done = w_tick && (r_phase == Q3);
  assign o_bit      = i_sda;

  // r_phase names the quarter that the next tick puts on the bus.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_div    <= '0;
      r_phase  <= Q0;
      r_cmd    <= CmdStart;
      o_scl_oe <= 1'b0;
      o_sda_oe <= 1'b0;
    end else begin
      if (!i_en || w_tick) r_div <= '0;
      else                 r_div <= r_div + 1'b1;
      if (w_tick) begin
        unique case (r_phase)
          Q0: begin
            if (i_cmd_valid) begin
              r_cmd    <= w_cmd;
              r_phase  <= Q1;
              o_scl_oe <= 1'b1;
              o_sda_oe <= (w_cmd == CmdStop) || ((w_cmd == CmdWrite) && !i_bit);
            end
          end
          Q1: begin
            o_scl_oe <= 1'b0;
            r_phase  <= Q2;
          end
          Q2: begin
            if (r_cmd == CmdStart) o_sda_oe <= 1'b1;
            if (r_cmd == CmdStop)  o_sda_oe <= 1'b0;
            r_phase <= Q3;
          end
          Q3: begin
            o_scl_oe <= (r_cmd != CmdStop);
            r_phase  <= Q0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/edid_reader.sv
// DDC master reading the EDID base block into a byte-write port.
// Optional EDID_CHECKSUM_EN: a non-zero byte sum turns a completed read into an error.
module edid_reader
  import edid_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 62,
  parameter int unsigned EDID_BYTES = 128,
  parameter logic [6:0]  DEV_ADDR   = 7'h50
) (
  input  logic       gclk,
  input  logic       rst,
  input  logic       edid_init,
  output logic       edid_read_ok,
  output logic       edid_err,
  output logic       edid_busy,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_i,
  output logic       edid_wr_en,
  output logic [7:0] edid_wr_addr,
  output logic [7:0] edid_wr_data
);

  localparam logic [8:0] LastIdx = 9'(EDID_BYTES - 1);

  state_e     r_state;
  logic [2:0] r_bit_cnt;
  logic [8:0] r_byte_cnt;
  logic [7:0] r_shift;
  logic [1:0] r_wsel;
  logic       r_fail;
  logic       w_cmd_valid, w_bit, w_cmd_done, w_bit_out, w_sum_ok, w_rbyte_end;
  cmd_e       w_cmd;
  logic [7:0] w_rx_byte;

  assign w_rx_byte   = {r_shift[6:0], w_bit_out};
  assign w_rbyte_end = (r_state == StRbyte) && w_cmd_done && (r_bit_cnt == 3'd7);

`ifdef EDID_CHECKSUM_EN
  logic [7:0] r_sum;
  assign w_sum_ok = (r_sum == 8'h00);
  always_ff @(posedge gclk) begin
    if (!rst || ((r_state == StIdle) && edid_init)) r_sum <= 8'h00;
    else if (w_rbyte_end)                             r_sum <= r_sum + w_rx_byte;
  end
`else
  assign w_sum_ok = 1'b1;
`endif

  always_comb begin
    w_cmd_valid = 1'b1;
    w_cmd       = CmdRead;
    w_bit       = 1'b1;
    unique case (r_state)
      StStart, StRstart: w_cmd = CmdStart;
      StWbyte: begin
        w_cmd = CmdWrite;
        w_bit = r_shift[7];
      end
      StWack, StRbyte: w_cmd = CmdRead;
      StMack: begin
        // Released SDA (NACK) on the final byte tells the slave to stop sending.
        w_cmd = CmdWrite;
        w_bit = (r_byte_cnt == LastIdx);
      end
      StStop:  w_cmd = CmdStop;
      default: w_cmd_valid = 1'b0;
    endcase
  end

  edid_i2c_bit #(
    .CLK_DIV (CLK_DIV)
  ) u_bit (
    .i_clk       (gclk),
    .i_rst       (rst),
    .i_en        (edid_busy),
    .i_cmd_valid (w_cmd_valid),
    .i_cmd       (w_cmd),
    .i_bit       (w_bit),
    .i_sda       (sda_i),
    .o_cmd_done  (w_cmd_done),
    .o_bit       (w_bit_out),
    .o_scl_oe    (scl_oe),
    .o_sda_oe    (sda_oe)
  );

  always_ff @(posedge gclk) begin
    if (!rst) begin
      r_state      <= StIdle;
      r_bit_cnt    <= 3'd0;
      r_byte_cnt   <= 9'd0;
      r_shift      <= 8'h00;
      r_wsel       <= 2'd0;
      r_fail       <= 1'b0;
      edid_read_ok <= 1'b0;
      edid_err     <= 1'b0;
      edid_busy    <= 1'b0;
      edid_wr_en   <= 1'b0;
      edid_wr_addr <= 8'h00;
      edid_wr_data <= 8'h00;
    end else begin
      edid_wr_en <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (edid_init) begin
            r_state      <= StStart;
            edid_read_ok <= 1'b0;
            edid_err     <= 1'b0;
            edid_busy    <= 1'b1;
            r_byte_cnt   <= 9'd0;
            r_fail       <= 1'b0;
          end
        end
        StStart: begin
          if (w_cmd_done) begin
            r_state   <= StWbyte;
            r_shift   <= addr_byte(DEV_ADDR, 1'b0);
            r_bit_cnt <= 3'd0;
            r_wsel    <= 2'd0;
          end
        end
        StRstart: begin
          if (w_cmd_done) begin
            r_state   <= StWbyte;
            r_shift   <= addr_byte(DEV_ADDR, 1'b1);
            r_bit_cnt <= 3'd0;
            r_wsel    <= 2'd2;
          end
        end
        StWbyte: begin
          if (w_cmd_done) begin
            r_shift   <= {r_shift[6:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= StWack;
          end
        end
        StWack: begin
          if (w_cmd_done) begin
            if (w_bit_out) begin
              r_fail  <= 1'b1;
              r_state <= StStop;
            end else begin
              unique case (r_wsel)
                2'd0: begin
                  r_state <= StWbyte;
                  r_shift <= DDC_WORD_ADDR;
                  r_wsel  <= 2'd1;
                end
                2'd1:    r_state <= StRstart;
                default: r_state <= StRbyte;
              endcase
            end
          end
        end
        StRbyte: begin
          if (w_cmd_done) begin
            r_shift   <= w_rx_byte;
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              edid_wr_en   <= 1'b1;
              edid_wr_addr <= r_byte_cnt[7:0];
              edid_wr_data <= w_rx_byte;
              r_state      <= StMack;
            end
          end
        end
        StMack: begin
          if (w_cmd_done) begin
            r_byte_cnt <= r_byte_cnt + 9'd1;
            r_state    <= (r_byte_cnt == LastIdx) ? StStop : StRbyte;
          end
        end
        StStop: begin
          if (w_cmd_done) r_state <= r_fail ? StErr : StDone;
        end
        StDone: begin
          edid_busy <= 1'b0;
          r_state   <= StIdle;
          if (w_sum_ok) edid_read_ok <= 1'b1;
          else          edid_err     <= 1'b1;
        end
        StErr: begin
          edid_busy <= 1'b0;
          edid_err  <= 1'b1;
          r_state   <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/edid_reader.md
Name: edid_reader

Overview:
- DDC/I2C master that reads the monitor's 128-byte EDID base block from device 0x50 at word address 0x00.
- Sits directly downstream of the system controller.
- Starts on its edid_init pulse. Returns edid_read_ok, which the controller waits on before raising HPD to the source.
- Each received byte is written out on a simple RAM write port, for the EDID store served to the source side.

Parameters:
- CLK_DIV, 62: gclk cycles per quarter-bit tick. 25 MHz / (4*62) gives about 100.8 kHz SCL.
- EDID_BYTES, 128: number of bytes read. Range 1..256.
- DEV_ADDR, 7'h50: 7-bit DDC device address.

Ports:
- gclk  in  1  system clock, 25 MHz
- rst  in  1  reset; synchronous, active-low (already decided)
- edid_init  in  1  one-cycle start request
- edid_read_ok  out  1  level; read completed successfully
- edid_err  out  1  level; read aborted (NACK, or checksum failure)
- edid_busy  out  1  transfer in progress
- scl_oe  out  1  1 = drive DDC SCL low; 0 = release
- sda_oe  out  1  1 = drive DDC SDA low; 0 = release
- sda_i  in  1  DDC SDA pad input, already synchronised
- edid_wr_en  out  1  one-cycle byte write strobe
- edid_wr_addr  out  8  byte index 0..EDID_BYTES-1
- edid_wr_data  out  8  received byte

Behaviour:
- Reset (rst=0 on a gclk edge):
  - All outputs go to 0; scl_oe=sda_oe=0 (bus released).
  - State returns to IDLE and the tick divider clears.
  - Applies mid-transfer too: no STOP is generated, the bus is simply released.
- Tick generation:
  - Divider counts 0..CLK_DIV-1 and only while busy.
  - It emits a one-cycle tick at CLK_DIV-1.
- Bit timing: each bit is 4 ticks.
  - q0: SCL low; drive SDA.
  - q1: release SCL.
  - q2: sample sda_i (SCL high).
  - q3: SCL low.
  - START: SDA falls while SCL is released.
  - STOP: SDA rises while SCL is released.
- Bytes are MSB first.
- States: IDLE, START, WBYTE, WACK, RSTART, RBYTE, MACK, STOP, DONE, ERR.
- IDLE:
  - edid_init=1 moves to START.
  - On entry to START: edid_read_ok and edid_err clear, edid_busy=1, byte count clears.
- Transfer sequence:
  - START, then WBYTE {DEV_ADDR,0}, then WACK, then WBYTE 0x00, then WACK.
  - Then RSTART (repeated start), then WBYTE {DEV_ADDR,1}, then WACK.
  - Then RBYTE/MACK repeated EDID_BYTES times.
  - Then STOP, then DONE.
- WACK:
  - sda_i=1 at q2 is a NACK: set a fail flag and go to STOP, then ERR.
- RBYTE:
  - After the 8th bit, pulse edid_wr_en for one gclk.
  - The pulse carries edid_wr_addr = byte count and edid_wr_data = the shifted byte.
- MACK:
  - Master drives ACK (SDA low) for all bytes except the last, which gets NACK (SDA released).
- DONE: edid_read_ok=1, edid_busy=0, return to IDLE. edid_read_ok holds until the next accepted edid_init or reset.
- ERR: edid_err=1, edid_busy=0, return to IDLE. Same hold rule as edid_read_ok.
- edid_init while edid_busy=1 is ignored; no restart.
- edid_read_ok and edid_err are never both 1.
- Byte count is 9 bits, so EDID_BYTES=256 does not wrap before the compare.
- Clock stretching is not supported; SCL is never sampled.
- Latency: a full 128-byte read takes (4 + 3*9 + 128*9 + 2) bits * 248 cycles, about 0.3 M gclk cycles (~12 ms). This is well inside the controller's HPD window.

Optional Feature:
- Macro: EDID_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum of all received bytes (mod 256) is kept.
  - At DONE, sum != 0 goes to ERR (edid_err=1) instead of setting edid_read_ok.
  - Bytes are still written out.
- Undefined: no sum logic; a completed read always sets edid_read_ok.

Decomposition:
- Package edid_pkg: state encodings, DDC_WORD_ADDR=8'h00, quarter-phase encodings.
- One sub-module, edid_i2c_bit. It is the tick divider plus the 4-phase bit engine.
  - Commands: START, STOP, WRITE_BIT, READ_BIT.
  - Signals: cmd_valid/cmd_done handshake; bit_in/bit_out.
  - Outputs: scl_oe, sda_oe.
- The top FSM sequences bytes and ACKs over this engine.

Test Plan:
- Reset: hold rst=0 for 3 cycles. All outputs read 0 and scl_oe=sda_oe=0.
- Normal read, slave model at 0x50 ACKing and returning byte i = i:
  - Exactly 128 edid_wr_en pulses occur, with addr=data=0..127.
  - Bus sequence: START, 0xA0, 0x00, repeated START, 0xA1.
  - Master ACKs bytes 0..126 and NACKs byte 127, then STOP.
  - Result: edid_read_ok=1, edid_err=0.
- No slave (SDA always released): NACK on 0xA0, then STOP, then edid_err=1. Zero write pulses; edid_read_ok=0.
- edid_init pulsed again mid-read: the transfer completes unchanged with exactly 128 writes.
- Reset asserted during byte 40: SCL/SDA release the next cycle and busy=0. A new edid_init then restarts at byte 0.
- With EDID_CHECKSUM_EN:
  - Bytes 0..126 = i and byte 127 = 0xBF give edid_read_ok=1.
  - Byte 127 = 0x7F instead gives edid_err=1.
